// File: rtl/smc_stream_if.sv
// smc_stream_if: device beat input and result strobe bundle for smc_stream_calc
interface smc_stream_if #(parameter int IN_W = 3, parameter int OUT_W = 10);
  logic in_valid;
  logic [IN_W-1:0] w;
  logic [IN_W-1:0] vgs;
  logic [IN_W-1:0] vds;
  logic [1:0] mode;
  logic out_valid;
  logic [OUT_W-1:0] out_n;
  modport master(output in_valid, w, vgs, vds, mode, input out_valid, out_n);
  modport slave(input in_valid, w, vgs, vds, mode, output out_valid, out_n);
endinterface

// File: rtl/smc_stream_calc.sv
// smc_stream_calc: serial MOSFET Id/gm calculator with insertion-sorted top/bottom-K reduction
module smc_stream_calc #(
  parameter int N_DEV = 6,
  parameter int K = 3,
  parameter int IN_W = 3,
  parameter int OUT_W = 10
) (
  input logic clk,
  input logic rst,
  smc_stream_if.slave bus
);
  localparam int VW = 3 * IN_W + 1;
  localparam int CW = $clog2(N_DEV);
  localparam int SW = VW + $clog2((K + 3) * K) + 1;
  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0] mode_q;
  logic [OUT_W-1:0] res, res_n;
  logic [VW-1:0] id_a[N_DEV], gm_a[N_DEV], id_n[N_DEV], gm_n[N_DEV], idb[N_DEV], gmb[N_DEV];
  logic [VW-1:0] ew, eo, ed, sq, id_v, gm_v;
  logic [IN_W-1:0] vov;
  logic [SW-1:0] sum;
  logic acc, first, last, triode;
  always_comb begin
    vov = bus.vgs - IN_W'(1);
    ew = VW'(bus.w);
    eo = VW'(vov);
    ed = VW'(bus.vds);
    triode = eo > ed;
    sq = triode ? ((eo * ed) << 1) - ed * ed : eo * eo;
    id_v = bus.vgs == '0 ? '0 : (ew * sq) / VW'(3);
    gm_v = bus.vgs == '0 ? '0 : ((ew * (triode ? ed : eo)) << 1) / VW'(3);
  end
  assign acc = bus.in_valid && state != CALC;
  assign first = acc && state != LOAD;
  assign last = acc && state == LOAD && cnt == CW'(N_DEV - 1);
  // The first beat of a frame inserts into an empty list, so no separate clear cycle is needed
  always_comb begin
    for (int j = 0; j < N_DEV; j++) begin
      idb[j] = first ? '0 : id_a[j];
      gmb[j] = first ? '0 : gm_a[j];
    end
  end
  for (genvar i = 0; i < N_DEV; i++) begin : g_ins
    if (i == 0) begin : g_head
      assign id_n[i] = idb[i] >= id_v ? idb[i] : id_v;
      assign gm_n[i] = gmb[i] >= gm_v ? gmb[i] : gm_v;
    end else begin : g_tail
      assign id_n[i] = idb[i] >= id_v ? idb[i] : idb[i-1] >= id_v ? id_v : idb[i-1];
      assign gm_n[i] = gmb[i] >= gm_v ? gmb[i] : gmb[i-1] >= gm_v ? gm_v : gmb[i-1];
    end
  end
  always_comb begin
    nxt = state;
    if (state == CALC) nxt = OUT;
    else if (last) nxt = CALC;
    else if (first) nxt = LOAD;
    else if (state == OUT) nxt = IDLE;
  end
  always_comb begin
    sum = '0;
    for (int r = 0; r < K; r++)
      sum += mode_q[0] ? SW'(mode_q[1] ? id_a[r] : id_a[N_DEV-K+r]) * SW'(3 + r)
                       : SW'(mode_q[1] ? gm_a[r] : gm_a[N_DEV-K+r]);
    res_n = OUT_W'(sum);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      mode_q <= '0;
      res <= '0;
      for (int j = 0; j < N_DEV; j++) begin
        id_a[j] <= '0;
        gm_a[j] <= '0;
      end
    end else begin
      state <= nxt;
      if (first) begin
        cnt <= CW'(1);
        mode_q <= bus.mode;
      end else if (acc) cnt <= cnt + CW'(1);
      if (acc) begin
        id_a <= id_n;
        gm_a <= gm_n;
      end
      if (state == CALC) res <= res_n;
    end
  end
  assign bus.out_valid = state == OUT;
  assign bus.out_n = state == OUT ? res : '0;
endmodule
